typing_judge: RTL and testbench
===============================

# typing_judge

Game-logic stage directly downstream of the PS/2 keyboard front end. It turns the `asc`/`clra` pair into one event per physical key press. Each press is judged against a pseudo-random target letter, and the block keeps hit, miss and combo counters plus a per-letter time limit. Its outputs drive the score display and target-letter display of the typing game.

## Interface
Parameters:
- `SEED`, 8'h5A: LFSR reset value; must be nonzero.
- `TIMEOUT`, 50_000_000: cycles allowed per target letter.
- `MAX_MISS`, 8'd10: miss count that ends the game.

Ports:
- `clk` in 1: system clock, the same clock as the keyboard front end.
- `clr` in 1: synchronous, active-high reset.
- `asc` in 8: ASCII code from the keyboard stage.
- `clra` in 1: 1 = no key held or ASCII cleared; 0 = `asc` valid.
- `start` in 1: single-cycle pulse that starts or restarts a game.
- `target` out 8: ASCII of the current target letter, 'a'..'z'; 8'h00 when not playing.
- `hit_count` out 8: correct presses, saturating at 255.
- `miss_count` out 8: wrong presses plus timeouts, saturating at 255.
- `combo` out 8: consecutive hits, saturating at 255.
- `key_valid` out 1: one-cycle pulse per judged press.
- `key_hit` out 1: qualifies `key_valid`; 1 = the press matched the target.
- `playing` out 1: FSM is in PLAY.
- `game_over` out 1: FSM is in OVER.

## Operation
- **FSM states**
  - IDLE: entered on reset.
  - IDLE→PLAY on `start`.
  - PLAY→OVER when `miss_count` becomes ≥ `MAX_MISS`.
  - OVER→PLAY on `start`.
  - PLAY→PLAY on `start` restarts the game.
- **Entering or restarting PLAY**
  - Clears `hit_count`, `miss_count`, `combo` and the timer.
  - `target` is derived from the current LFSR value; the LFSR does not step.
- **Press event**
  - Condition: registered `clra_q`=1 and `clra`=0, while in PLAY.
  - A held key produces exactly one event.
  - Releasing and pressing again produces a new event.
- **Normalisation**
  - 'A'..'Z' (8'h41..8'h5A) is mapped to lowercase by adding 8'h20.
  - Codes outside 'a'..'z' after mapping are ignored: no event, no pulse, no counter change.
- **Hit** (normalised code == `target`)
  - `hit_count`+1 and `combo`+1.
  - LFSR steps once; new `target` is taken from the new LFSR value.
  - Timer clears; `key_valid`=1, `key_hit`=1.
- **Miss** (normalised code ≠ `target`)
  - `miss_count`+1 and `combo`=0.
  - `target` and LFSR are unchanged.
  - Timer clears; `key_valid`=1, `key_hit`=0.
- **Timeout**
  - Condition: timer == `TIMEOUT`-1 in PLAY with no event that cycle.
  - `miss_count`+1, `combo`=0.
  - LFSR steps; new target.
  - Timer clears; no `key_valid` pulse.
- **LFSR**
  - 8-bit Fibonacci, shifted left: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- **Target mapping**
  - Let v = lfsr[4:0]. If v ≥ 26 then v = v − 26.
  - `target` = 8'h61 + v.
- **Timer**
  - Width is $clog2(`TIMEOUT`).
  - Counts only in PLAY; held at 0 otherwise.
- **OVER**
  - Ignores presses and timeouts.
  - Holds all counters and `target` until `start`.
- **Saturation**
  - Counters stop at 255; `combo` still clears on a miss.
  - `miss_count` saturation does not block the transition to OVER.

## Timing
- **Reset values** (`clr`=1 at a rising edge)
  - State IDLE, LFSR=`SEED`, `clra_q`=1, timer 0.
  - `target`=0, all counters 0.
  - `key_valid`, `key_hit`, `playing`, `game_over` = 0.
  - `clr` has priority over `start` and over any event.
  - `clr` asserted mid-game aborts the game immediately.
- **Press latency**
  - Falling `clra` sampled at edge N.
  - Counters, `target`, `key_valid` and `key_hit` update at edge N+1.
  - The press is judged against `target` as it stood before edge N+1.
- **Start latency**
  - `start` sampled at edge N → `playing`=1, `target` valid and counters clear at edge N+1.
- **Game over**
  - The miss that reaches `MAX_MISS` updates `miss_count` at edge N+1.
  - `game_over`=1 and `playing`=0 also at edge N+1.
  - `target` keeps its last value.
- **Simultaneous events**
  - Press and timeout in the same cycle: the press wins and the timeout is discarded.
  - `start` and a press in the same cycle: `start` wins and the press is dropped.
- **Outputs**: all registered; no combinational path from input to output.

## Test plan
- Reset, then `start` with `SEED`=8'h5A → `target`=8'h61 ('a'), `playing`=1, all counters 0.
- From that state, press 'A' (`asc`=8'h41, `clra` 1→0) → `key_valid`, `key_hit`=1, `hit_count`=1, `combo`=1, `target`=8'h75 ('u'). Hold the key 100 cycles → no further event.
- With `target`='u', press 'x' (8'h78) → `key_hit`=0, `miss_count`=1, `combo`=0, `target` stays 8'h75. Press '5' (8'h35) → no pulse, counters unchanged.
- With `TIMEOUT`=20, idle in PLAY for 20 cycles → `miss_count`+1, `target` changes, no `key_valid` pulse.
- Force a press and a timer expiry in the same cycle → only the press is counted, timer = 0.
- With `MAX_MISS`=3, make 3 misses → `game_over`=1 at the third miss's N+1 edge. A subsequent press is ignored. `start` → counters 0, `playing`=1.

Source files
------------

// File: rtl/typing_judge.sv
// Typing-game judge: turns keyboard ASCII/clear pairs into single press events,
// scores them against an LFSR-chosen target letter and enforces a per-letter time limit.
module typing_judge #(
    parameter logic [7:0] SEED     = 8'h5A,
    parameter int         TIMEOUT  = 50_000_000,
    parameter logic [7:0] MAX_MISS = 8'd10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] asc,
    input  logic       clra,
    input  logic       start,
    output logic [7:0] target,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic [7:0] combo,
    output logic       key_valid,
    output logic       key_hit,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Fold the low five LFSR bits onto the 26 lowercase letters.
    function automatic logic [7:0] letter_of(input logic [7:0] v);
        logic [4:0] idx;
        if (v[4:0] >= 5'd26) begin
            idx = v[4:0] - 5'd26;
        end else begin
            idx = v[4:0];
        end
        return 8'h61 + {3'b000, idx};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t        state_r, state_n;
    logic [7:0]    lfsr_r, lfsr_n;
    logic          clra_q_r;
    logic [TW-1:0] timer_r, timer_n;
    logic [7:0]    target_n, hit_n, miss_n, combo_n;
    logic          key_valid_n, key_hit_n;
    logic [7:0]    norm_s;
    logic          letter_s, press_s;

    // Lowercase the key code and qualify a fresh press of a letter key.
    always_comb begin
        if (asc >= 8'h41 && asc <= 8'h5A) begin
            norm_s = asc + 8'h20;
        end else begin
            norm_s = asc;
        end
        letter_s = (norm_s >= 8'h61) && (norm_s <= 8'h7A);
        press_s  = clra_q_r && !clra && letter_s;
    end

    // Next-state and next-output logic; start overrides any press or timeout.
    always_comb begin
        state_n     = state_r;
        lfsr_n      = lfsr_r;
        target_n    = target;
        hit_n       = hit_count;
        miss_n      = miss_count;
        combo_n     = combo;
        timer_n     = {TW{1'b0}};
        key_valid_n = 1'b0;
        key_hit_n   = 1'b0;
        if (start) begin
            state_n  = PLAY;
            target_n = letter_of(lfsr_r);
            hit_n    = 8'd0;
            miss_n   = 8'd0;
            combo_n  = 8'd0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (press_s) begin
                        key_valid_n = 1'b1;
                        if (norm_s == target) begin
                            key_hit_n = 1'b1;
                            hit_n     = sat_inc(hit_count);
                            combo_n   = sat_inc(combo);
                            lfsr_n    = lfsr_step(lfsr_r);
                            target_n  = letter_of(lfsr_step(lfsr_r));
                        end else begin
                            miss_n  = sat_inc(miss_count);
                            combo_n = 8'd0;
                        end
                    end else if (timer_r == TIMER_LAST) begin
                        miss_n   = sat_inc(miss_count);
                        combo_n  = 8'd0;
                        lfsr_n   = lfsr_step(lfsr_r);
                        target_n = letter_of(lfsr_step(lfsr_r));
                    end else begin
                        timer_n = timer_r + TW'(1);
                    end
                    if (miss_n >= MAX_MISS) begin
                        state_n = OVER;
                    end else begin
                        state_n = PLAY;
                    end
                end
                IDLE, OVER: state_n = state_r;
                default:    state_n = IDLE;
            endcase
        end
    end

    // State, LFSR, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r    <= IDLE;
            lfsr_r     <= SEED;
            clra_q_r   <= 1'b1;
            timer_r    <= {TW{1'b0}};
            target     <= 8'h00;
            hit_count  <= 8'd0;
            miss_count <= 8'd0;
            combo      <= 8'd0;
            key_valid  <= 1'b0;
            key_hit    <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_r    <= state_n;
            lfsr_r     <= lfsr_n;
            clra_q_r   <= clra;
            timer_r    <= timer_n;
            target     <= target_n;
            hit_count  <= hit_n;
            miss_count <= miss_n;
            combo      <= combo_n;
            key_valid  <= key_valid_n;
            key_hit    <= key_hit_n;
            playing    <= (state_n == PLAY);
            game_over  <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_typing_judge.sv
// Scoreboard bench for typing_judge: stimulus queues the expected judged presses,
// a negedge monitor compares each key_valid pulse; state checks are made inline.
module tb_typing_judge;

    logic       clk = 1'b0;
    logic       clr, start, clra;
    logic [7:0] asc;
    logic [7:0] target, hit_count, miss_count, combo;
    logic       key_valid, key_hit, playing, game_over;

    always #5 clk = ~clk;

    typing_judge #(
        .SEED(8'h5A),
        .TIMEOUT(20),
        .MAX_MISS(8'd3)
    ) dut (
        .clk(clk), .clr(clr), .asc(asc), .clra(clra), .start(start),
        .target(target), .hit_count(hit_count), .miss_count(miss_count),
        .combo(combo), .key_valid(key_valid), .key_hit(key_hit),
        .playing(playing), .game_over(game_over)
    );

    typedef struct packed {
        logic       hit;
        logic [7:0] hits;
        logic [7:0] misses;
        logic [7:0] cmb;
        logic [7:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input logic h, input logic [7:0] hits, input logic [7:0] misses,
                                input logic [7:0] cmb, input logic [7:0] tgt);
        exp_t e;
        e.hit = h; e.hits = hits; e.misses = misses; e.cmb = cmb; e.tgt = tgt;
        sb.push_back(e);
    endtask

    task automatic press(input logic [7:0] code, input int hold);
        asc  = code;
        clra = 1'b0;
        tick(hold);
        clra = 1'b1;
        asc  = 8'h00;
        tick(2);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_counts(input string tag, input logic [7:0] h, input logic [7:0] m,
                                input logic [7:0] c, input logic [7:0] t);
        check8({tag, " hit_count"}, hit_count, h);
        check8({tag, " miss_count"}, miss_count, m);
        check8({tag, " combo"}, combo, c);
        check8({tag, " target"}, target, t);
    endtask

    // Monitor: every judged press must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_key_valid: got pulse hit=%b, expected none", key_hit);
            end else begin
                e = sb.pop_front();
                check8("mon key_hit", {7'd0, key_hit}, {7'd0, e.hit});
                check8("mon hit_count", hit_count, e.hits);
                check8("mon miss_count", miss_count, e.misses);
                check8("mon combo", combo, e.cmb);
                check8("mon target", target, e.tgt);
            end
        end
    end

    initial begin
        clr = 1'b1; start = 1'b0; clra = 1'b1; asc = 8'h00;
        tick(3);
        check_counts("reset", 8'd0, 8'd0, 8'd0, 8'h00);
        check8("reset playing", {7'd0, playing}, 8'd0);
        check8("reset game_over", {7'd0, game_over}, 8'd0);
        check8("reset key_valid", {7'd0, key_valid}, 8'd0);
        clr = 1'b0;
        tick(1);

        // Start: SEED 5A -> 'a'
        do_start();
        check_counts("start", 8'd0, 8'd0, 8'd0, 8'h61);
        check8("start playing", {7'd0, playing}, 8'd1);

        // Uppercase hit held 10 cycles: one event, LFSR B4 -> 'u'
        expect_press(1'b1, 8'd1, 8'd0, 8'd1, 8'h75);
        press(8'h41, 10);
        // Wrong letter
        expect_press(1'b0, 8'd1, 8'd1, 8'd0, 8'h75);
        press(8'h78, 1);
        // Non-letter ignored
        press(8'h35, 1);
        check_counts("digit", 8'd1, 8'd1, 8'd0, 8'h75);
        // Lowercase hit: LFSR 69 -> 'j'
        expect_press(1'b1, 8'd2, 8'd1, 8'd1, 8'h6A);
        press(8'h75, 1);

        // Restart mid-game, then idle into a timeout: LFSR D2 -> 's'
        do_start();
        check_counts("restart", 8'd0, 8'd0, 8'd0, 8'h6A);
        tick(19);
        check8("pre-timeout miss_count", miss_count, 8'd0);
        tick(1);
        check_counts("timeout", 8'd0, 8'd1, 8'd0, 8'h73);

        // Press on the same cycle the timer expires: press wins, LFSR A4 -> 'e'
        tick(19);
        expect_press(1'b1, 8'd1, 8'd1, 8'd1, 8'h65);
        press(8'h73, 1);
        tick(17);
        check8("timer cleared by press", miss_count, 8'd1);
        tick(1);
        check_counts("second timeout", 8'd1, 8'd2, 8'd0, 8'h69);

        // Fresh game, three misses end it
        do_start();
        check_counts("game2", 8'd0, 8'd0, 8'd0, 8'h69);
        expect_press(1'b0, 8'd0, 8'd1, 8'd0, 8'h69);
        press(8'h7A, 1);
        expect_press(1'b0, 8'd0, 8'd2, 8'd0, 8'h69);
        press(8'h7A, 1);
        expect_press(1'b0, 8'd0, 8'd3, 8'd0, 8'h69);
        asc = 8'h7A; clra = 1'b0;
        tick(1);
        check8("over game_over", {7'd0, game_over}, 8'd1);
        check8("over playing", {7'd0, playing}, 8'd0);
        clra = 1'b1; asc = 8'h00;
        tick(2);
        press(8'h69, 1);
        tick(25);
        check_counts("over hold", 8'd0, 8'd3, 8'd0, 8'h69);

        // Start together with a press: start wins, press dropped
        asc = 8'h7A; clra = 1'b0;
        do_start();
        tick(3);
        clra = 1'b1; asc = 8'h00;
        tick(1);
        check_counts("start+press", 8'd0, 8'd0, 8'd0, 8'h69);
        check8("restart playing", {7'd0, playing}, 8'd1);
        check8("restart game_over", {7'd0, game_over}, 8'd0);

        // clr aborts the game
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check8("abort playing", {7'd0, playing}, 8'd0);
        check8("abort target", target, 8'h00);

        tick(3);
        check8("scoreboard drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
